// File: rtl/debug_dump_ctrl.sv
// debug_dump_ctrl: walks the Top debug read ports over the register file (and data memory
// when DEBUG_DUMP_DM_EN is defined) and streams each word out as a {src, idx, data} beat.
module debug_dump_ctrl #(
    parameter int XLEN     = 32,
    parameter int RF_DEPTH = 32,
    parameter int DM_WORDS = 64,
    parameter int RD_LAT   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(RF_DEPTH)-1:0] debug_addr_RF,
    input  logic [XLEN-1:0]             debug_data_RF,
    output logic [XLEN-1:0]             debug_addr_DF,
    input  logic [XLEN-1:0]             debug_data_DF,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_src,
    output logic [15:0]                 out_idx,
    output logic [XLEN-1:0]             out_data
);

    localparam int RF_AW = $clog2(RF_DEPTH);
`ifdef DEBUG_DUMP_DM_EN
    localparam int MAX_ENT = (RF_DEPTH > DM_WORDS) ? RF_DEPTH : DM_WORDS;
`else
    localparam int MAX_ENT = RF_DEPTH;
`endif
    localparam int IDX_W = (MAX_ENT > 1) ? $clog2(MAX_ENT) : 1;
    localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_DEPTH - 1);
`ifdef DEBUG_DUMP_DM_EN
    localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DM_WORDS - 1);
`endif
    localparam int LAT_LAST_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [1:0] LAT_LAST = 2'(LAT_LAST_I);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        wait_q, wait_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [RF_AW-1:0]  addr_rf_q, addr_rf_d;
    logic              last_entry;
    logic              load_addr;
    logic              capture;

`ifdef DEBUG_DUMP_DM_EN
    logic              src_q, src_d;
    logic [XLEN-1:0]   addr_df_q, addr_df_d;

    assign last_entry    = src_q && (idx_q == DM_LAST);
    assign out_src       = src_q;
    assign debug_addr_DF = addr_df_q;
`else
    logic              dm_data_unused;

    assign last_entry     = (idx_q == RF_LAST);
    assign out_src        = 1'b0;
    assign debug_addr_DF  = '0;
    assign dm_data_unused = ^debug_data_DF;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        data_d    = data_q;
        addr_rf_d = addr_rf_q;
        load_addr = 1'b0;
        capture   = 1'b0;
`ifdef DEBUG_DUMP_DM_EN
        src_d     = src_q;
        addr_df_d = addr_df_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ADDR;
                    idx_d     = '0;
                    load_addr = 1'b1;
`ifdef DEBUG_DUMP_DM_EN
                    src_d     = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                wait_d = '0;
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Address is held here; data is trusted only on the last counted cycle.
                if (wait_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (last_entry) begin
                        state_d = S_FIN;
                    end else begin
                        state_d   = S_ADDR;
                        load_addr = 1'b1;
`ifdef DEBUG_DUMP_DM_EN
                        if (!src_q && (idx_q == RF_LAST)) begin
                            src_d = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
`else
                        idx_d = idx_q + IDX_W'(1);
`endif
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
`ifdef DEBUG_DUMP_DM_EN
            data_d = src_q ? debug_data_DF : debug_data_RF;
`else
            data_d = debug_data_RF;
`endif
        end

        // Only the source being read moves its address; the other keeps its last value.
        if (load_addr) begin
`ifdef DEBUG_DUMP_DM_EN
            if (src_d) begin
                addr_df_d = XLEN'({idx_d, 2'b00});
            end else begin
                addr_rf_d = idx_d[RF_AW-1:0];
            end
`else
            addr_rf_d = idx_d[RF_AW-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            data_q    <= '0;
            addr_rf_q <= '0;
`ifdef DEBUG_DUMP_DM_EN
            src_q     <= 1'b0;
            addr_df_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
            addr_rf_q <= addr_rf_d;
`ifdef DEBUG_DUMP_DM_EN
            src_q     <= src_d;
            addr_df_q <= addr_df_d;
`endif
        end
    end

    assign busy          = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_EMIT);
    assign done          = (state_q == S_FIN);
    assign out_valid     = (state_q == S_EMIT);
    assign out_idx       = 16'(idx_q);
    assign out_data      = data_q;
    assign debug_addr_RF = addr_rf_q;

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Bench for debug_dump_ctrl: two instances (RD_LAT 0 and 2) against a beat-timeline model,
// with the Top debug ports emulated by arrays behind an address delay line of RD_LAT cycles.
module tb_debug_dump_ctrl;

    localparam int XLEN = 32;
    localparam int RF_N = 32;
    localparam int DM_N = 64;
`ifdef DEBUG_DUMP_DM_EN
    localparam int N_ENT = RF_N + DM_N;
`else
    localparam int N_ENT = RF_N;
`endif
    localparam int LAT0 = 0;
    localparam int LAT1 = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [1:0] busy_w, done_w, valid_w, src_w, ready_w;
    logic [4:0]      arf_w  [2];
    logic [XLEN-1:0] adf_w  [2];
    logic [XLEN-1:0] drf_w  [2];
    logic [XLEN-1:0] ddf_w  [2];
    logic [XLEN-1:0] data_w [2];
    logic [15:0]     idx_w  [2];

    logic [XLEN-1:0] rf [RF_N];
    logic [XLEN-1:0] dm [DM_N];
    logic [4:0]      rfp1, rfp2;
    logic [XLEN-1:0] dfp1, dfp2;

    always #5 clk = ~clk;

    debug_dump_ctrl #(.XLEN(XLEN), .RF_DEPTH(RF_N), .DM_WORDS(DM_N), .RD_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
        .debug_addr_RF(arf_w[0]), .debug_data_RF(drf_w[0]),
        .debug_addr_DF(adf_w[0]), .debug_data_DF(ddf_w[0]),
        .out_valid(valid_w[0]), .out_ready(ready_w[0]), .out_src(src_w[0]),
        .out_idx(idx_w[0]), .out_data(data_w[0])
    );

    debug_dump_ctrl #(.XLEN(XLEN), .RF_DEPTH(RF_N), .DM_WORDS(DM_N), .RD_LAT(LAT1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
        .debug_addr_RF(arf_w[1]), .debug_data_RF(drf_w[1]),
        .debug_addr_DF(adf_w[1]), .debug_data_DF(ddf_w[1]),
        .out_valid(valid_w[1]), .out_ready(ready_w[1]), .out_src(src_w[1]),
        .out_idx(idx_w[1]), .out_data(data_w[1])
    );

    // Top emulation: data appears RD_LAT cycles after the address it belongs to.
    assign drf_w[0] = rf[arf_w[0]];
    assign ddf_w[0] = dm[adf_w[0][7:2]];
    always @(posedge clk) begin
        rfp1 <= arf_w[1];
        rfp2 <= rfp1;
        dfp1 <= adf_w[1];
        dfp2 <= dfp1;
    end
    assign drf_w[1] = rf[rfp2];
    assign ddf_w[1] = dm[dfp2[7:2]];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit m_on = 1'b0;
    int lats [2] = '{LAT0, LAT1};

    // Model: each instance walks beats k = 0..N_ENT-1; beat k is valid once m_t >= RD_LAT+1.
    bit              m_act [2];
    bit              m_fin [2];
    bit              m_rstx [2];
    int              m_k [2];
    int              m_t [2];
    logic [4:0]      m_arf [2];
    logic [XLEN-1:0] m_adf [2];
    bit              stall_en = 1'b0;
    int              stall_n [2];

    int              done_cnt [2];
    int              s_cyc [2];
    int              d_cyc [2];
    int              h7 [2];
    int              a5 [2];
    int              fv [2];
    bit              dn [2];
    bit              fv_set [2];
    logic [XLEN-1:0] r0 [2];
    logic [XLEN-1:0] r31 [2];
    logic [XLEN-1:0] r5 [2];
    logic [XLEN-1:0] rdm3 [2];
    logic [XLEN-1:0] rdm3a [2];

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, want %0h (cycle %0d)", nm, i, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
            dn[i]       = 1'b0;
            h7[i]       = 0;
            a5[i]       = 0;
            fv_set[i]   = 1'b0;
            fv[i]       = -1;
            stall_n[i]  = 0;
        end
    endtask

    // One clock: check outputs at negedge, choose out_ready, advance the model, return after posedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            bit              ev;
            bit              bsrc;
            bit              rdy;
            int              bidx;
            logic [XLEN-1:0] bdata;
            ev    = m_act[i] && (m_t[i] >= lats[i] + 1);
            bsrc  = (m_k[i] >= RF_N);
            bidx  = bsrc ? m_k[i] - RF_N : m_k[i];
            bdata = bsrc ? dm[bidx] : rf[bidx];
            if (m_on) begin
                chk("busy", i, 64'(busy_w[i]), 64'(m_act[i]));
                chk("done", i, 64'(done_w[i]), 64'(m_fin[i]));
                chk("out_valid", i, 64'(valid_w[i]), 64'(ev));
                chk("debug_addr_RF", i, 64'(arf_w[i]), 64'(m_arf[i]));
                chk("debug_addr_DF", i, 64'(adf_w[i]), 64'(m_adf[i]));
                if (ev) begin
                    chk("out_src", i, 64'(src_w[i]), 64'(bsrc));
                    chk("out_idx", i, 64'(idx_w[i]), 64'(bidx));
                    chk("out_data", i, 64'(data_w[i]), 64'(bdata));
                end else if (m_rstx[i]) begin
                    chk("idle_out_src", i, 64'(src_w[i]), 64'd0);
                    chk("idle_out_idx", i, 64'(idx_w[i]), 64'd0);
                    chk("idle_out_data", i, 64'(data_w[i]), 64'd0);
                end
            end

            if (done_w[i]) begin
                done_cnt[i]++;
                if (!dn[i]) begin
                    dn[i]    = 1'b1;
                    d_cyc[i] = cyc;
                end
            end
            if (valid_w[i] && !fv_set[i]) begin
                fv_set[i] = 1'b1;
                fv[i]     = int'(idx_w[i]);
            end
            if (valid_w[i] && !src_w[i] && idx_w[i] == 16'd0)  r0[i]  = data_w[i];
            if (valid_w[i] && !src_w[i] && idx_w[i] == 16'd31) r31[i] = data_w[i];
            if (valid_w[i] && !src_w[i] && idx_w[i] == 16'd5)  r5[i]  = data_w[i];
            if (valid_w[i] && src_w[i] && idx_w[i] == 16'd3) begin
                rdm3[i]  = data_w[i];
                rdm3a[i] = adf_w[i];
            end
            if (valid_w[i] && !src_w[i] && idx_w[i] == 16'd7) h7[i]++;
            if (busy_w[i] && !valid_w[i] && arf_w[i] == 5'd5) a5[i]++;

            rdy = 1'b1;
            if (stall_en && ev && !bsrc && bidx == 7 && stall_n[i] < 10) begin
                rdy = 1'b0;
                stall_n[i]++;
            end
            ready_w[i] = rdy;
            if (valid_w[i] && rdy)
                $display("inst%0d beat src=%0d idx=%0d data=%08h", i, src_w[i], idx_w[i], data_w[i]);

            if (rst) begin
                m_act[i]  = 1'b0;
                m_fin[i]  = 1'b0;
                m_k[i]    = 0;
                m_t[i]    = 0;
                m_arf[i]  = '0;
                m_adf[i]  = '0;
                m_rstx[i] = 1'b1;
            end else if (m_fin[i]) begin
                m_fin[i] = 1'b0;
            end else if (m_act[i]) begin
                if (ev && rdy) begin
                    if (m_k[i] == N_ENT - 1) begin
                        m_act[i] = 1'b0;
                        m_fin[i] = 1'b1;
                    end else begin
                        m_k[i]++;
                        m_t[i] = 0;
                        if (m_k[i] >= RF_N) m_adf[i] = XLEN'((m_k[i] - RF_N) * 4);
                        else                m_arf[i] = 5'(m_k[i]);
                    end
                end else if (!ev) begin
                    m_t[i]++;
                end
            end else if (start) begin
                m_act[i]  = 1'b1;
                m_k[i]    = 0;
                m_t[i]    = 0;
                m_rstx[i] = 1'b0;
                m_arf[i]  = '0;
                s_cyc[i]  = cyc;
            end
        end
        m_on = m_on | rst;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep();
        for (int n = 0; n < 3000 && !(dn[0] && dn[1]); n++) step();
        chk("sweep_done_seen", 0, 64'(dn[0]), 64'd1);
        chk("sweep_done_seen", 1, 64'(dn[1]), 64'd1);
        repeat (3) step();
    endtask

    initial begin
        bit hit;
        rst     = 1'b1;
        start   = 1'b0;
        ready_w = 2'b11;
        for (int i = 0; i < RF_N; i++) rf[i] = 32'(i * 3);
        for (int i = 0; i < DM_N; i++) dm[i] = 32'h1000 + 32'(i * 5);
        dm[3] = 32'h55;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_fin[i] = 1'b0; m_rstx[i] = 1'b1;
            m_k[i] = 0; m_t[i] = 0; m_arf[i] = '0; m_adf[i] = '0;
            s_cyc[i] = 0; d_cyc[i] = 0;
            r0[i] = '1; r31[i] = '1; r5[i] = '1; rdm3[i] = '1; rdm3a[i] = '1;
        end
        clear_obs();

        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 64'(busy_w[i]), 64'd0);
            chk("rst_out_valid", i, 64'(valid_w[i]), 64'd0);
            chk("rst_addr_rf", i, 64'(arf_w[i]), 64'd0);
            chk("rst_out_data", i, 64'(data_w[i]), 64'd0);
        end
        rst = 1'b0;
        step();

        // Full sweep, no backpressure, xN = N*3.
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_sweep();
        chk("sweep_len", 0, 64'(d_cyc[0] - s_cyc[0] - 1), 64'(N_ENT * 2));
        chk("sweep_len", 1, 64'(d_cyc[1] - s_cyc[1] - 1), 64'(N_ENT * 4));
        for (int i = 0; i < 2; i++) begin
            chk("x0_data", i, 64'(r0[i]), 64'd0);
            chk("x31_data", i, 64'(r31[i]), 64'd93);
            chk("first_idx", i, 64'(fv[i]), 64'd0);
            chk("done_pulses", i, 64'(done_cnt[i]), 64'd1);
        end

        // x5 marker, stall on idx 7 for 10 cycles, ignored start near beat 10.
        rf[5] = 32'hDEADBEEF;
        clear_obs();
        stall_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 1000 && m_k[0] < 10; n++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_sweep();
        stall_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("x5_data", i, 64'(r5[i]), 64'hDEADBEEF);
            chk("idx7_hold_cycles", i, 64'(h7[i]), 64'd11);
            chk("addr5_before_valid", i, 64'(a5[i]), 64'(lats[i] + 1));
            chk("done_pulses_midstart", i, 64'(done_cnt[i]), 64'd1);
`ifdef DEBUG_DUMP_DM_EN
            chk("dm3_data", i, 64'(rdm3[i]), 64'h55);
            chk("dm3_addr", i, 64'(rdm3a[i]), 64'd12);
`endif
        end

        // Abort during the WAIT of beat 4 on the RD_LAT=2 instance.
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 500 && !hit; n++) begin
            if (m_act[1] && m_k[1] == 4 && m_t[1] == 1) hit = 1'b1;
            else step();
        end
        chk("reached_wait_beat4", 1, 64'(hit), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("abort_busy", i, 64'(busy_w[i]), 64'd0);
            chk("abort_out_valid", i, 64'(valid_w[i]), 64'd0);
        end
        repeat (5) step();
        for (int i = 0; i < 2; i++) chk("abort_no_done", i, 64'(done_cnt[i]), 64'd0);

        // Restart after abort begins again at idx 0.
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_sweep();
        for (int i = 0; i < 2; i++) begin
            chk("restart_first_idx", i, 64'(fv[i]), 64'd0);
            chk("restart_done_pulses", i, 64'(done_cnt[i]), 64'd1);
            chk("restart_x31_data", i, 64'(r31[i]), 64'd93);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
